// File: rtl/ifu_prefetch_pkg.sv
// ifu_prefetch_pkg
//   Constants shared by the prefetching fetch unit and its FIFO:
//   default data/address width, default reset PC, default fetch step, and a
//   helper that sizes occupancy counters.
package ifu_prefetch_pkg;

  localparam int          XLEN_WIDTH         = 32;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam int          INST_BYTES_DEFAULT = 4;

  // An occupancy counter must be able to hold DEPTH itself, hence the +1.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifu_prefetch_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with a combinational head view. There is no
//   write-to-read bypass: an entry pushed at edge N appears on head_data
//   after that edge. The flush input empties the FIFO by moving the read
//   pointer onto the write pointer. While flushing, any push or pop in the
//   same cycle is ignored.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset (empties the FIFO)
//   flush      in   drop every stored entry this cycle
//   push       in   write push_data at the tail
//   push_data  in   WIDTH-bit entry to store
//   pop        in   retire the head entry (caller guarantees non-empty)
//   head_data  out  oldest stored entry
//   count      out  current occupancy, 0..DEPTH
module sync_fifo
  import ifu_prefetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  // The storage array has no reset. Only the pointers and the count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // DEPTH is a power of two, so the AW-bit pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = mem[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch
//   Prefetching instruction fetch unit. It owns the fetch PC and issues
//   reads to a ROM with a 1-cycle latency. Returned words, tagged with their
//   PC, are stored in a DEPTH-entry FIFO and passed to decode over a
//   valid/ready handshake. A redirect flushes the FIFO and drops the read in
//   flight, then restarts fetch at the new target in the same cycle.
// Ports:
//   clk          in   clock
//   rst          in   synchronous active-high reset
//   rom_addr     out  ROM read address (combinational)
//   rom_en       out  ROM read strobe (combinational)
//   rom_data     in   ROM data, valid the cycle after rom_en
//   redirect     in   flush and restart fetch at redirect_pc
//   redirect_pc  in   new fetch target; the low two bits are ignored
//   inst_valid   out  the FIFO head holds an instruction
//   inst_ready   in   decode accepts the head this cycle
//   inst         out  head instruction (0 when not valid)
//   inst_pc      out  PC of the head instruction (0 when not valid)
//   fifo_count   out  FIFO occupancy
module ifu_prefetch
  import ifu_prefetch_pkg::*;
#(
  parameter int              XLEN       = XLEN_WIDTH,
  parameter int              DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC   = XLEN'(RESET_PC_DEFAULT),
  parameter int              INST_BYTES = INST_BYTES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [XLEN-1:0]        rom_addr,
  output logic                   rom_en,
  input  logic [XLEN-1:0]        rom_data,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [XLEN-1:0]        inst,
  output logic [XLEN-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int             CW          = count_width(DEPTH);
  localparam logic [CW:0]    DEPTH_LIMIT = (CW + 1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]   fetch_pc_reg;
  logic [XLEN-1:0]   inflight_pc_reg;
  logic              inflight_reg;

  logic [CW-1:0]     count;
  logic [2*XLEN-1:0] head;
  logic              pop;
  logic              push;
  logic [CW:0]       credit;
  logic [XLEN-1:0]   target_pc;

  assign target_pc = redirect_pc & ALIGN_MASK;

  always_comb begin
    inst_valid = ~rst & ~redirect & (count != '0);
    pop        = inst_valid & inst_ready;
    // Slots that are taken once this cycle ends, excluding any new issue.
    // A pop in this cycle frees its slot right away, which keeps the unit
    // at one instruction per cycle even with DEPTH=2.
    credit     = {1'b0, count} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop};
    rom_addr   = redirect ? target_pc : fetch_pc_reg;
    if (rst) begin
      rom_en = 1'b0;
    end else if (redirect) begin
      // The FIFO is flushed this cycle, so the new target always has room.
      rom_en = 1'b1;
    end else begin
      rom_en = credit < DEPTH_LIMIT;
    end
    // A response that arrives during a redirect or reset belongs to the
    // old stream, so it is dropped.
    push       = inflight_reg & ~redirect & ~rst;
    inst       = inst_valid ? head[XLEN-1:0] : '0;
    inst_pc    = inst_valid ? head[2*XLEN-1:XLEN] : '0;
    fifo_count = rst ? '0 : count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      inflight_pc_reg <= RESET_PC;
      inflight_reg    <= 1'b0;
    end else begin
      inflight_reg <= rom_en;
      if (rom_en) begin
        inflight_pc_reg <= rom_addr;
        fetch_pc_reg    <= rom_addr + PC_STEP;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({inflight_pc_reg, rom_data}),
    .pop       (pop),
    .head_data (head),
    .count     (count)
  );

endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch
//   Directed and random stimulus for ifu_prefetch. The reference is an
//   abstract stream model: a queue of buffered PCs, one optional
//   outstanding fetch, and a ROM whose word at byte address a is
//   32'h1000_0000 + a/4.
module tb_ifu_prefetch;

  localparam int          XLEN       = 32;
  localparam int          DEPTH      = 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          INST_BYTES = 4;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic        rom_en;
  logic [31:0] rom_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [2:0]  fifo_count;

  ifu_prefetch #(
    .XLEN       (XLEN),
    .DEPTH      (DEPTH),
    .RESET_PC   (RESET_PC),
    .INST_BYTES (INST_BYTES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Synchronous ROM with 1-cycle read latency.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom_word(rom_addr);
  end

  // Stream model state
  logic [31:0] q_pc[$];
  bit          m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_fetch_pc;

  int vectors;
  int miscompares;

  // Values seen in the most recent step, used by the directed checks
  logic        obs_valid;
  logic        obs_en;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;
  logic [31:0] obs_inst;
  logic [2:0]  obs_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, compare outputs mid-cycle, then advance.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic        e_valid;
    logic        e_pop;
    logic        e_en;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    int          e_cnt;
    rst         = r;
    redirect    = rd;
    redirect_pc = rpc;
    inst_ready  = rdy;
    #1;
    vectors++;
    e_pop  = 1'b0;
    e_addr = '0;
    if (r) begin
      e_valid = 1'b0;
      e_en    = 1'b0;
      e_cnt   = 0;
      e_pc    = '0;
    end else begin
      e_cnt   = q_pc.size();
      e_valid = (e_cnt != 0) && !rd;
      e_pop   = e_valid && rdy;
      if (rd) begin
        e_en   = 1'b1;
        e_addr = rpc & ~32'h3;
      end else begin
        e_en   = (e_cnt + int'(m_inflight) - int'(e_pop)) < DEPTH;
        e_addr = m_fetch_pc;
      end
      e_pc = e_valid ? q_pc[0] : 32'h0;
    end
    check("rom_en", 64'(rom_en), 64'(e_en));
    if (e_en) check("rom_addr", 64'(rom_addr), 64'(e_addr));
    check("inst_valid", 64'(inst_valid), 64'(e_valid));
    check("inst_pc", 64'(inst_pc), 64'(e_pc));
    check("inst", 64'(inst), e_valid ? 64'(rom_word(e_pc)) : 64'h0);
    check("fifo_count", 64'(fifo_count), 64'(e_cnt));
    assert (int'(fifo_count) <= DEPTH) else begin
      miscompares++;
      $error("FAIL count_bound: observed %0d, expected <= %0d", fifo_count, DEPTH);
    end
    obs_valid = inst_valid;
    obs_en    = rom_en;
    obs_addr  = rom_addr;
    obs_pc    = inst_pc;
    obs_inst  = inst;
    obs_cnt   = fifo_count;
    if (e_pop) $display("pop pc=%08h inst=%08h count=%0d", inst_pc, inst, fifo_count);
    @(posedge clk);
    if (r) begin
      q_pc.delete();
      m_inflight = 1'b0;
      m_fetch_pc = RESET_PC;
    end else begin
      if (rd) begin
        q_pc.delete();
      end else begin
        if (e_pop) void'(q_pc.pop_front());
        if (m_inflight) q_pc.push_back(m_inflight_pc);
      end
      m_inflight = e_en;
      if (e_en) begin
        m_inflight_pc = e_addr;
        m_fetch_pc    = e_addr + INST_BYTES;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic        r_r;
    logic        r_rd;
    logic [31:0] r_pc;
    logic        r_rdy;
    vectors     = 0;
    miscompares = 0;
    rom_data    = '0;

    // Reset state
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Streaming from reset with decode always ready
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      if (k == 0) begin
        check("c0_en", 64'(obs_en), 64'h1);
        check("c0_addr", 64'(obs_addr), 64'h0);
      end
      if (k == 2) begin
        check("c2_valid", 64'(obs_valid), 64'h1);
        check("c2_inst", 64'(obs_inst), 64'h1000_0000);
        check("c2_pc", 64'(obs_pc), 64'h0);
      end
      if (k >= 2) check("stream_pc", 64'(obs_pc), 64'(4 * (k - 2)));
    end

    // Backpressure from reset, then release
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    check("bp_count", 64'(obs_cnt), 64'd4);
    check("bp_en", 64'(obs_en), 64'h0);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("bp_order", 64'(obs_pc), 64'(4 * k));
    end

    // Redirect to 0x40 with three entries buffered
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h40, 1'b1);
    check("rd_count", 64'(obs_cnt), 64'd3);
    check("rd_valid", 64'(obs_valid), 64'h0);
    check("rd_addr", 64'(obs_addr), 64'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rd2_valid", 64'(obs_valid), 64'h1);
    check("rd2_pc", 64'(obs_pc), 64'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("rd3_pc", 64'(obs_pc), 64'h44);

    // Misaligned redirect target
    step(1'b0, 1'b1, 32'h43, 1'b1);
    check("mis_addr", 64'(obs_addr), 64'h40);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mis_pc", 64'(obs_pc), 64'h40);

    // Back-to-back redirects: only the second target survives
    step(1'b0, 1'b1, 32'h80, 1'b1);
    step(1'b0, 1'b1, 32'hC0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("b2b_pc", 64'(obs_pc), 64'hC0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'h0, 1'b1);

    // Reset mid-stream with the FIFO loaded and a read outstanding
    step(1'b0, 1'b1, 32'h100, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mr_valid", 64'(obs_valid), 64'h0);
    check("mr_count", 64'(obs_cnt), 64'h0);
    check("mr_addr", 64'(obs_addr), 64'(RESET_PC));
    step(1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    check("mr_first", 64'(obs_pc), 64'(RESET_PC));

    // Random traffic, including targets near the top of the address space
    for (int k = 0; k < 600; k++) begin
      r_r   = ($urandom_range(0, 99) == 0);
      r_rd  = ($urandom_range(0, 15) == 0);
      r_pc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom();
      r_rdy = (k % 100 < 30) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r_r, r_rd, r_pc, r_rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
